nes_ppu_lite: RTL and testbench

- Simplified NES picture processor with VGA output; sits beside the 6502 core on the shared 100 MHz clock.
- Generates the slow ppuclk/cpuclk strobes and decodes CPU registers $2000-$2007.
- Fetches background tiles from external nametable RAM and CHR memory, and drives 640x480@60 RGB565 video with the 256x240 NES image pixel-doubled and centred.

---
 rtl/nes_ppu_lite_if.sv | 19 +
 rtl/nes_ppu_lite.sv | 238 +++++++++++++++++++++++
 tb/tb_nes_ppu_lite.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_ppu_lite_if.sv
// nes_ppu_lite_if: 6502-side register bus of the PPU.
// master (CPU): ea, dout, rd, wreq out; ppu_dout, nmi in. slave (PPU): mirrored.
interface nes_ppu_lite_if;
    logic [15:0] ea;
    logic [7:0]  dout;
    logic        rd;
    logic        wreq;
    logic [7:0]  ppu_dout;
    logic        nmi;

    modport master (
        output ea, dout, rd, wreq,
        input  ppu_dout, nmi
    );
    modport slave (
        input  ea, dout, rd, wreq,
        output ppu_dout, nmi
    );
endinterface

// File: rtl/nes_ppu_lite.sv
// nes_ppu_lite: simplified NES PPU, background-only, 640x480 VGA (2x, centred).
// Ports: clk, rst (async high); bus (CPU regs $2000-$2007, ppu_dout, nmi);
// red/green/blue/hs/vs video; vaddr/vdata/vram_we nametable; faddr/fdata CHR;
// ppuclk/cpuclk strobes. Define PPU_NMI_EN to drive nmi from vblank & CTRL[7].
module nes_ppu_lite #(
    parameter int PPU_DIV = 20,
    parameter int CPU_DIV = 60
) (
    input  logic          clk,
    input  logic          rst,
    nes_ppu_lite_if.slave bus,
    output logic [4:0]    red,
    output logic [5:0]    green,
    output logic [4:0]    blue,
    output logic          hs,
    output logic          vs,
    output logic [10:0]   vaddr,
    input  logic [7:0]    vdata,
    output logic          vram_we,
    output logic [12:0]   faddr,
    input  logic [7:0]    fdata,
    output logic          ppuclk,
    output logic          cpuclk
);
    localparam logic [7:0] P_HALF = 8'(PPU_DIV / 2 - 1);
    localparam logic [7:0] C_HALF = 8'(CPU_DIV / 2 - 1);

    logic [7:0] pdiv, cdiv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pdiv   <= '0;
            cdiv   <= '0;
            ppuclk <= 1'b0;
            cpuclk <= 1'b0;
        end else begin
            if (pdiv == P_HALF) begin
                pdiv   <= '0;
                ppuclk <= ~ppuclk;
            end else begin
                pdiv <= pdiv + 8'd1;
            end
            if (cdiv == C_HALF) begin
                cdiv   <= '0;
                cpuclk <= ~cpuclk;
            end else begin
                cdiv <= cdiv + 8'd1;
            end
        end
    end

    // ph is the clk phase inside one VGA pixel; pe ends the pixel.
    logic [1:0] ph;
    logic [9:0] x, y;
    logic       pe, eol;

    assign pe  = (ph == 2'd3);
    assign eol = pe && (x == 10'd799);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= '0;
            x  <= '0;
            y  <= '0;
        end else begin
            ph <= ph + 2'd1;
            if (pe) begin
                if (x == 10'd799) begin
                    x <= '0;
                    y <= (y == 10'd524) ? '0 : y + 10'd1;
                end else begin
                    x <= x + 10'd1;
                end
            end
        end
    end

    assign hs = !((x >= 10'd656) && (x <= 10'd751));
    assign vs = !((y == 10'd490) || (y == 10'd491));

    // Tile windows are 16 VGA pixels aligned to x=48, so the clk index
    // inside a window is simply {x[3:0], ph}.
    logic [5:0] tclk;
    logic [9:0] xo;
    logic [7:0] line;
    logic       fbusy;
    logic [7:0] tile, plo, phi, sh_lo, sh_hi;
    logic       ctrl_bg;

    assign tclk  = {x[3:0], ph};
    assign xo    = x - 10'd48;
    assign line  = y[8:1];
    assign fbusy = (x >= 10'd48) && (x < 10'd560) && (y < 10'd480)
                && (tclk < 6'd6);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile  <= '0;
            plo   <= '0;
            phi   <= '0;
            sh_lo <= '0;
            sh_hi <= '0;
        end else begin
            if (fbusy && tclk == 6'd1) tile <= vdata;
            if (fbusy && tclk == 6'd3) plo  <= fdata;
            if (fbusy && tclk == 6'd5) phi  <= fdata;
            if (pe && x[3:0] == 4'hF) begin
                sh_lo <= plo;
                sh_hi <= phi;
            end else if (pe && x[0]) begin
                sh_lo <= {sh_lo[6:0], 1'b0};
                sh_hi <= {sh_hi[6:0], 1'b0};
            end
        end
    end

    // CPU register file
    logic        sel, wreq_q, rd_q, wr_edge, rd_edge;
    logic [2:0]  ra;
    logic        ctrl_inc, ctrl_nmi, mask_bg, wlatch, vblank, pend;
    logic [13:0] ptr, inc;
    logic [10:0] pend_addr;
    logic [5:0]  pal [32];
    logic [4:0]  pidx;
    logic        is_pal, is_vram, vb_set, vb_clr;

    assign sel     = (bus.ea[15:13] == 3'b001);
    assign ra      = bus.ea[2:0];
    assign wr_edge = sel && bus.wreq && !wreq_q;
    assign rd_edge = sel && bus.rd && !rd_q;
    assign inc     = ctrl_inc ? 14'd32 : 14'd1;
    assign is_pal  = (ptr[13:5] == 9'h1F8);
    assign is_vram = ptr[13] && (ptr[13:8] != 6'h3F);
    assign vb_set  = eol && (y == 10'd479);
    assign vb_clr  = eol && (y == 10'd523);
    assign vram_we = pend && !fbusy;

    // $3F10/14/18/1C alias the backdrop entries.
    always_comb begin
        pidx = ptr[4:0];
        if (pidx[4] && pidx[1:0] == 2'b00) pidx[4] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wreq_q    <= 1'b0;
            rd_q      <= 1'b0;
            ctrl_inc  <= 1'b0;
            ctrl_bg   <= 1'b0;
            ctrl_nmi  <= 1'b0;
            mask_bg   <= 1'b0;
            wlatch    <= 1'b0;
            vblank    <= 1'b0;
            pend      <= 1'b0;
            pend_addr <= '0;
            ptr       <= '0;
            for (int i = 0; i < 32; i++) pal[i] <= '0;
        end else begin
            wreq_q <= bus.wreq;
            rd_q   <= bus.rd;
            if (vram_we) pend <= 1'b0;
            if (vb_clr) vblank <= 1'b0;
            if (rd_edge && ra == 3'd2) begin
                vblank <= 1'b0;
                wlatch <= 1'b0;
            end
            if (rd_edge && ra == 3'd7) ptr <= ptr + inc;
            // set is last so it beats a coincident STATUS read
            if (vb_set) vblank <= 1'b1;
            if (wr_edge) begin
                case (ra)
                    3'd0: begin
                        ctrl_inc <= bus.dout[2];
                        ctrl_bg  <= bus.dout[4];
                        ctrl_nmi <= bus.dout[7];
                    end
                    3'd1: mask_bg <= bus.dout[3];
                    3'd6: begin
                        if (!wlatch) ptr[13:8] <= bus.dout[5:0];
                        else         ptr[7:0]  <= bus.dout;
                        wlatch <= ~wlatch;
                    end
                    3'd7: begin
                        if (is_pal) begin
                            pal[pidx] <= bus.dout[5:0];
                        end else if (is_vram) begin
                            pend      <= 1'b1;
                            pend_addr <= ptr[10:0];
                        end
                        ptr <= ptr + inc;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.ppu_dout = '0;
        if (sel) begin
            case (ra)
                3'd2:    bus.ppu_dout = {vblank, 7'b0};
                3'd7:    if (is_pal) bus.ppu_dout = {2'b00, pal[pidx]};
                default: ;
            endcase
        end
    end

    always_comb begin
        vaddr = '0;
        faddr = '0;
        if (fbusy && tclk == 6'd0)      vaddr = {1'b0, line[7:3], xo[8:4]};
        else if (vram_we)               vaddr = pend_addr;
        if (fbusy && tclk == 6'd2)      faddr = {ctrl_bg, tile, 1'b0, line[2:0]};
        else if (fbusy && tclk == 6'd4) faddr = {ctrl_bg, tile, 1'b1, line[2:0]};
    end

    logic [1:0] pix;
    logic [5:0] c;
    logic       act;

    assign pix   = {sh_hi[7], sh_lo[7]};
    assign c     = pal[{3'b000, pix}];
    assign act   = mask_bg && (x >= 10'd64) && (x < 10'd576) && (y < 10'd480);
    assign red   = act ? {c[5:4], c[5:4], c[5]} : '0;
    assign green = act ? {c[3:2], c[3:2], c[3:2]} : '0;
    assign blue  = act ? {c[1:0], c[1:0], c[1]} : '0;

`ifdef PPU_NMI_EN
    assign bus.nmi = vblank & ctrl_nmi;
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.ea[12:3], xo[9], xo[3:0]};
`else
    assign bus.nmi = 1'b0;
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.ea[12:3], xo[9], xo[3:0], ctrl_nmi};
`endif
endmodule

// File: tb/tb_nes_ppu_lite.sv
// tb_nes_ppu_lite: directed scoreboard bench for nes_ppu_lite.
// Register reads and VRAM writes are checked by queue-popping monitors.
module tb_nes_ppu_lite;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  red;
    logic [5:0]  green;
    logic [4:0]  blue;
    logic        hs, vs, vram_we, ppuclk, cpuclk;
    logic [10:0] vaddr;
    logic [7:0]  vdata, fdata;
    logic [12:0] faddr;

    nes_ppu_lite_if bus();

    nes_ppu_lite dut (
        .clk(clk), .rst(rst), .bus(bus),
        .red(red), .green(green), .blue(blue), .hs(hs), .vs(vs),
        .vaddr(vaddr), .vdata(vdata), .vram_we(vram_we),
        .faddr(faddr), .fdata(fdata), .ppuclk(ppuclk), .cpuclk(cpuclk)
    );

    always #5 clk = ~clk;

`ifdef PPU_NMI_EN
    localparam bit NMI_ON = 1'b1;
`else
    localparam bit NMI_ON = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int n;
    logic [7:0]  rd_q[$];
    string       rd_nm[$];
    logic [10:0] vw_q[$];

    always @(posedge clk or posedge rst)
        if (rst) n <= 0;
        else     n <= n + 1;

    function automatic int mx(int nn); return (nn / 4) % 800; endfunction
    function automatic int mph(int nn); return nn % 4; endfunction
    function automatic int my(int nn); return (nn / 3200) % 525; endfunction
    function automatic bit fbusy_m(int nn);
        int x = mx(nn);
        return x >= 48 && x < 560 && my(nn) < 480 && ((x % 16) * 4 + mph(nn)) < 6;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [15:0] a, logic [7:0] d);
        bus.ea = a; bus.dout = d; bus.wreq = 1'b1;
        cyc(2);
        bus.wreq = 1'b0;
        cyc(6);
    endtask

    task automatic rd(logic [15:0] a, logic [7:0] e, string nm);
        rd_q.push_back(e); rd_nm.push_back(nm);
        bus.ea = a; bus.rd = 1'b1;
        cyc(2);
        bus.rd = 1'b0;
        cyc(2);
    endtask

    task automatic wait_n(int m, int r, string nm);
        int k = 0;
        while (n % m != r && k < 8000) begin cyc(1); k++; end
        if (n % m != r) begin
            checks++; errors++;
            $display("FAIL %s: timeout waiting for n%%%0d==%0d", nm, m, r);
        end
    endtask

    // read monitor: compares ppu_dout on each rising rd
    logic rd_prev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (bus.rd === 1'b1 && !rd_prev) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: ppu_dout %0h, nothing expected", bus.ppu_dout);
            end else begin
                chk(rd_nm.pop_front(), {24'd0, bus.ppu_dout}, {24'd0, rd_q.pop_front()});
            end
        end
        rd_prev = bus.rd;
    end

    // VRAM write monitor: address order and no overlap with fetch clk 0..5
    initial forever begin
        @(negedge clk);
        if (vram_we === 1'b1) begin
            if (vw_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL vram_we_unexpected: vaddr %0h, none pending", vaddr);
            end else begin
                chk("vram_vaddr", {21'd0, vaddr}, {21'd0, vw_q.pop_front()});
                chk("vram_we_in_fetch", {31'd0, fbusy_m(n)}, 32'd0);
            end
        end
    end

    initial begin
        int hs_lo, k, ln, ex, ef;
        bus.ea = '0; bus.dout = '0; bus.rd = 1'b0; bus.wreq = 1'b0;
        vdata = 8'h01; fdata = 8'hFF;
        cyc(3);
        chk("rst_ppuclk", {31'd0, ppuclk}, 0);
        chk("rst_cpuclk", {31'd0, cpuclk}, 0);
        chk("rst_sync", {30'd0, hs, vs}, 3);
        chk("rst_rgb", {16'd0, red, green, blue}, 0);
        chk("rst_mem", {8'd0, vram_we, vaddr, faddr}, 0);
        chk("rst_bus", {23'd0, bus.nmi, bus.ppu_dout}, 0);
        rst = 1'b0;

        for (int i = 0; i < 200; i++) begin
            cyc(1);
            chk("ppuclk", {31'd0, ppuclk}, (n / 10) % 2);
            chk("cpuclk", {31'd0, cpuclk}, (n / 30) % 2);
            chk("sync_early", {30'd0, hs, vs}, 3);
        end

        // one full line with MASK=0
        wait_n(3200, 0, "line_start_mask0");
        hs_lo = 0;
        for (int i = 0; i < 3200; i++) begin
            @(negedge clk);
            if (mph(n) == 0 && !hs) hs_lo++;
            chk("hs", {31'd0, hs}, (mx(n) >= 656 && mx(n) <= 751) ? 0 : 1);
            chk("rgb_mask0", {16'd0, red, green, blue}, 0);
        end
        chk("hs_low_count", hs_lo, 96);
        chk("vs_line", {31'd0, vs}, 1);
        cyc(1);

        // palette and register reads
        rd(16'h2002, 8'h00, "status_idle");
        wr(16'h2006, 8'h3F); wr(16'h2006, 8'h00); wr(16'h2007, 8'h2A);
        wr(16'h2006, 8'h3F); wr(16'h2006, 8'h00);
        rd(16'h2007, 8'h2A, "pal0_read");
        wr(16'h2007, 8'h15);
        wr(16'h2006, 8'h3F); wr(16'h2006, 8'h01);
        rd(16'h2007, 8'h15, "ptr_3f01");
        rd(16'h2007, 8'h00, "pal2_read");
        wr(16'h2007, 8'h3F);
        wr(16'h2006, 8'h3F); wr(16'h2006, 8'h10); wr(16'h2007, 8'h0C);
        wr(16'h2006, 8'h3F); wr(16'h2006, 8'h00);
        rd(16'h2007, 8'h0C, "pal_mirror_3f10");
        wr(16'h2006, 8'h3F); wr(16'h2006, 8'h10);
        rd(16'h2007, 8'h0C, "pal_read_3f10");
        wr(16'h2006, 8'h3F); wr(16'h2006, 8'h03);
        rd(16'h6007, 8'h00, "unselected");
        rd(16'h2001, 8'h00, "reg1_read");
        rd(16'h3007, 8'h3F, "pal3_via_3007");
        wr(16'h2006, 8'h20); wr(16'h2006, 8'h00);
        rd(16'h2007, 8'h00, "nonpal_read");

        // background: every pixel p=3 -> palette[3]=$3F -> white
        wr(16'h2000, 8'h00);
        wr(16'h2001, 8'h08);
        wait_n(3200, 0, "line_start_white");
        for (int i = 0; i < 3200; i++) begin
            @(negedge clk);
            ex = (mx(n) >= 64 && mx(n) < 576) ? 32'hFFFF : 0;
            chk("rgb_white", {16'd0, red, green, blue}, ex);
            ln = my(n) / 2;
            k = (mx(n) % 16) * 4 + mph(n);
            if (mx(n) >= 48 && mx(n) < 560) begin
                ef = 32'h010 | (ln % 8);
                if (k == 0) chk("fetch_vaddr", {21'd0, vaddr},
                                ((ln / 8) << 5) | ((mx(n) - 48) / 16));
                if (k == 2) chk("fetch_lo", {19'd0, faddr}, ef);
                if (k == 4) chk("fetch_hi", {19'd0, faddr}, ef | 8);
            end
        end
        cyc(1);

        // queued VRAM writes with +32 increment
        wr(16'h2000, 8'h04);
        rd(16'h2002, 8'h00, "status_clr_latch");
        wr(16'h2006, 8'h20); wr(16'h2006, 8'h00);
        k = 0;
        while (!(mx(n) % 16 == 15 && mph(n) == 3 && mx(n) >= 47 && mx(n) <= 527)
               && k < 4000) begin cyc(1); k++; end
        chk("align_fetch", {31'd0, fbusy_m(n + 1)}, 1);
        vw_q.push_back(11'h000); wr(16'h2007, 8'h11);
        vw_q.push_back(11'h020); wr(16'h2007, 8'h22);
        vw_q.push_back(11'h040); wr(16'h2007, 8'h33);
        cyc(10);
        chk("vram_q_drained", vw_q.size(), 0);

        // vertical boundaries via forced line counter
        force dut.y = 10'd489; #1 chk("vs_489", {31'd0, vs}, 1);
        force dut.y = 10'd490; #1 chk("vs_490", {31'd0, vs}, 0);
        force dut.y = 10'd491; #1 chk("vs_491", {31'd0, vs}, 0);
        force dut.y = 10'd492; #1 chk("vs_492", {31'd0, vs}, 1);
        k = 0;
        while (mx(n) != 100 && k < 4000) begin cyc(1); k++; end
        force dut.y = 10'd479; #1 chk("rgb_y479", {16'd0, red, green, blue}, 32'hFFFF);
        force dut.y = 10'd480; #1 chk("rgb_y480", {16'd0, red, green, blue}, 0);

        // vblank set coinciding with a STATUS read edge
        wr(16'h2000, 8'h80);
        rd(16'h2002, 8'h00, "status_pre");
        force dut.y = 10'd479;
        wait_n(3200, 3199, "pre_wrap");
        rd_q.push_back(8'h00); rd_nm.push_back("status_coincident");
        bus.ea = 16'h2002; bus.rd = 1'b1;
        cyc(2);
        bus.rd = 1'b0;
        cyc(2);
        chk("nmi_vblank", {31'd0, bus.nmi}, {31'd0, NMI_ON});
        rd(16'h2002, 8'h80, "status_vblank");
        chk("nmi_after_read", {31'd0, bus.nmi}, 0);
        rd(16'h2002, 8'h00, "status_second");

        // vblank cleared when line becomes 524
        wait_n(3200, 0, "wrap_set");
        chk("nmi_set2", {31'd0, bus.nmi}, {31'd0, NMI_ON});
        force dut.y = 10'd523;
        cyc(1);
        wait_n(3200, 0, "wrap_clr");
        chk("nmi_cleared", {31'd0, bus.nmi}, 0);
        rd(16'h2002, 8'h00, "status_cleared");
        release dut.y;

        cyc(10);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
